// File: rtl/grayscale_stream.sv
// Streaming RGBA-to-gray converter: 3-stage fixed-latency pipeline feeding a
// credit-guarded output FIFO, with per-beat bypass/luma/average mode select.
module grayscale_stream #(
    parameter int DATA_WIDTH = 512,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            mode_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  beats_in,
    output logic [CNT_WIDTH-1:0]  beats_out,
    output logic                  err_overflow
);

    localparam int unsigned LANES = DATA_WIDTH / 32;
    localparam int unsigned PW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = PW + 1;
    localparam int unsigned CRW   = CW + 1;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_LUMA   = 2'b01,
        MODE_AVG    = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    // Pipeline state
    logic                  r_s1_v, r_s2_v;
    mode_e                 r_s1_mode, r_s2_mode;
    logic [DATA_WIDTH-1:0] r_s1_pix, r_s2_pix;
    logic [15:0]           r_s1_pr [LANES];
    logic [15:0]           r_s1_pg [LANES];
    logic [15:0]           r_s1_pb [LANES];
    logic [15:0]           r_s2_luma [LANES];
    logic [9:0]            r_s2_sum [LANES];

    // FIFO state
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [CNT_WIDTH-1:0]  r_beats_in, r_beats_out;
    logic                  r_err_overflow;

    logic                  w_accept, w_push, w_pop, w_full, w_push_ok;
    logic [CRW-1:0]        w_credit;
    logic [DATA_WIDTH-1:0] w_packed;

    // Credit covers every beat already stored or still travelling through S1/S2,
    // so a beat accepted now always finds a free FIFO slot when it lands.
    assign w_credit  = CRW'(r_count) + CRW'(r_s1_v) + CRW'(r_s2_v);
    assign ready_in  = !reset && (w_credit < CRW'(FIFO_DEPTH));
    assign w_accept  = valid_in && ready_in;

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign valid_out = (r_count != '0);
    assign w_pop     = valid_out && ready_out;
    assign w_push    = r_s2_v;
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign data_out  = r_mem[r_rd_ptr];

    assign busy         = r_s1_v || r_s2_v || (r_count != '0);
    assign beats_in     = r_beats_in;
    assign beats_out    = r_beats_out;
    assign err_overflow = r_err_overflow;

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < LANES; i++) begin
            r_s1_pr[i] <= 16'(77)  * 16'(data_in[32*i +: 8]);
            r_s1_pg[i] <= 16'(150) * 16'(data_in[32*i+8 +: 8]);
            r_s1_pb[i] <= 16'(29)  * 16'(data_in[32*i+16 +: 8]);
        end
        r_s1_pix  <= data_in;
        r_s1_mode <= mode_e'(mode_in);

        for (int unsigned i = 0; i < LANES; i++) begin
            r_s2_luma[i] <= r_s1_pr[i] + r_s1_pg[i] + r_s1_pb[i];
            r_s2_sum[i]  <= 10'(r_s1_pix[32*i +: 8]) + 10'(r_s1_pix[32*i+8 +: 8])
                          + 10'(r_s1_pix[32*i+16 +: 8]);
        end
        r_s2_pix  <= r_s1_pix;
        r_s2_mode <= r_s1_mode;
    end

    always_comb begin
        w_packed = r_s2_pix;
        for (int unsigned i = 0; i < LANES; i++) begin
            case (r_s2_mode)
                MODE_LUMA: w_packed[32*i +: 24] = {3{8'(r_s2_luma[i] >> 8)}};
                MODE_AVG:  w_packed[32*i +: 24] = {3{8'((19'(r_s2_sum[i]) * 19'd171) >> 9)}};
                default:   w_packed[32*i +: 24] = r_s2_pix[32*i +: 24];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_packed;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_v         <= 1'b0;
            r_s2_v         <= 1'b0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_beats_in     <= '0;
            r_beats_out    <= '0;
            r_err_overflow <= 1'b0;
        end else begin
            r_s1_v <= w_accept;
            r_s2_v <= r_s1_v;

            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_push && w_full && !w_pop) begin
                r_err_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end

            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (w_accept) begin
                r_beats_in <= r_beats_in + CNT_WIDTH'(1);
            end
            if (w_pop) begin
                r_beats_out <= r_beats_out + CNT_WIDTH'(1);
            end
        end
    end

endmodule
